keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Matrix-keypad front end. Walks the column index through all columns and drives it, with an enable, straight into the parameterised n-to-m one-hot decoder that energises the columns.
- Reads the row lines back, debounces them, and reports one encoded key per press as a single-cycle strobe plus a held level.
- Sits upstream of the column decoder and feeds the keypad consumer logic.

Parameters:
COL_BITS, 2, column index width; matches the decoder's input width (2**COL_BITS columns)
ROW_BITS, 2, row index width; ROWS = 2**ROW_BITS row inputs
SCAN_DIV, 1000, clk cycles each column is held before sampling; must be >= 4
DEBOUNCE, 4, consecutive agreeing dwell-end samples required for press and for release; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
row_in  input  ROWS  raw row lines, active-high, asynchronous to clk
col_sel  output  COL_BITS  column index to decoder x
col_en  output  1  decoder enable
key_code  output  COL_BITS+ROW_BITS  {column, row} of last accepted key
key_valid  output  1  one-cycle strobe when key_code updates
key_held  output  1  high from acceptance until debounced release

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low clears all state immediately, regardless of clk.
- Reset values: col_sel=0, col_en=0, key_code=0, key_valid=0, key_held=0, FSM=SCAN, all counters 0, synchroniser 0.
- col_en is registered. It goes 1 on the first clk edge after rst_n deasserts and stays 1 thereafter.
- row_in passes through a 2-flop synchroniser. All decisions use the synchronised value, sampled only at dwell end.
- Dwell counter runs 0..SCAN_DIV-1 and wraps. Dwell end is the cycle where count == SCAN_DIV-1.
- Row decode: the lowest-index high row wins. Candidate code = {col_sel, row}.
- FSM SCAN:
  - At dwell end, no row high: col_sel increments mod 2**COL_BITS, so 3 wraps to 0.
  - At dwell end, a row high: latch the candidate and set stable_cnt=1. col_sel freezes.
  - If DEBOUNCE==1, accept immediately. Otherwise go to DEBOUNCE.
- FSM DEBOUNCE (col_sel frozen):
  - At each dwell end, candidate equal to the latched one: stable_cnt++. When stable_cnt reaches DEBOUNCE, accept.
  - Candidate differs, or no row high: clear stable_cnt and return to SCAN. col_sel is not advanced; the same column is rescanned.
- Accept:
  - On the clk edge after the accepting dwell end: key_code <= latched candidate, key_valid=1 for exactly one cycle, key_held=1.
  - FSM goes to HELD.
- FSM HELD (col_sel frozen):
  - At each dwell end, latched row bit low: rel_cnt++.
  - Latched row bit high: rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE: key_held=0 next cycle, rel_cnt=0, col_sel advances by 1 (mod), FSM=SCAN.
  - Other rows going high during HELD are ignored. No n-key rollover.
- key_code holds its value after release until the next accept.
- key_valid never asserts twice for one press.
- Reset asserted mid-DEBOUNCE or mid-HELD: outputs drop immediately to reset values. No key_valid is emitted.

Test Plan:
(Bench runs SCAN_DIV=4, DEBOUNCE=2, COL_BITS=2, ROW_BITS=2. The keypad model drives row_in[r]=1 only while col_sel equals the pressed key's column.)
1. Reset, then idle with no keys -> all outputs 0 during reset; col_en=1 one cycle after release; col_sel steps 0,1,2,3,0 every 4 cycles; key_valid stays 0.
2. Press key (col 1, row 2) steadily -> exactly one key_valid pulse with key_code=4'b0110, two dwell ends after first detection; key_held=1; col_sel stays 1.
3. Bounce: key (col 1, row 2) present for one dwell only -> no key_valid; key_held stays 0; scanning resumes at col_sel=1, then continues 2,3,...
4. Release after test 2: drop the row -> key_held falls after 2 consecutive low dwell ends; col_sel then advances to 2; key_code remains 4'b0110.
5. Rows 0 and 3 both pressed on col 3 -> key_valid with key_code=4'b1100 (lowest row wins).
6. Assert rst_n low mid-HELD, between clk edges -> key_held, key_valid, key_code, col_en and col_sel go 0 immediately without a clk edge; after release, scanning restarts from col 0.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle of keypad_scanner: row lines in, column drive and
// encoded key report out.
interface keypad_scanner_if #(
  parameter int COL_BITS = 2,
  parameter int ROW_BITS = 2
);
  localparam int ROWS = 2 ** ROW_BITS;
  localparam int KW   = COL_BITS + ROW_BITS;

  logic [ROWS-1:0]     row_in;
  logic [COL_BITS-1:0] col_sel;
  logic                col_en;
  logic [KW-1:0]       key_code;
  logic                key_valid;
  logic                key_held;

  // key_valid is a one-cycle strobe with no ready: the consumer must take
  // key_code in the cycle key_valid is high; key_held is a plain level.
  modport master (
    input  row_in,
    output col_sel, col_en, key_code, key_valid, key_held
  );

  modport slave (
    output row_in,
    input  col_sel, col_en, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks columns, debounces synchronised row reads at
// the end of each column dwell and reports one {column,row} code per press.
module keypad_scanner #(
  parameter int COL_BITS = 2,
  parameter int ROW_BITS = 2,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp,
  output logic [1:0]       dbg_state
);
  localparam int ROWS = 2 ** ROW_BITS;
  localparam int KW   = COL_BITS + ROW_BITS;
  localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW   = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_DEB  = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       dwell_q, dwell_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                col_en_q, col_en_d;
  logic [ROWS-1:0]     meta_q, meta_d;
  logic [ROWS-1:0]     sync_q, sync_d;
  logic [KW-1:0]       cand_q, cand_d;
  logic [DW-1:0]       stable_q, stable_d;
  logic [DW-1:0]       rel_q, rel_d;
  logic [KW-1:0]       code_q, code_d;
  logic                valid_q, valid_d;
  logic                held_q, held_d;

  logic                dwell_end;
  logic                row_hit;
  logic [ROW_BITS-1:0] row_idx;
  logic [KW-1:0]       cand;
  logic                latched_low;

  // Priority decode: iterating downward leaves the lowest high row in row_idx.
  always_comb begin
    row_hit = 1'b0;
    row_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (sync_q[i]) begin
        row_hit = 1'b1;
        row_idx = ROW_BITS'(i);
      end
    end
  end

  assign dwell_end   = (dwell_q == CW'(SCAN_DIV - 1));
  assign cand        = {col_q, row_idx};
  assign latched_low = ~sync_q[cand_q[ROW_BITS-1:0]];

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_end ? '0 : dwell_q + CW'(1);
    col_d    = col_q;
    col_en_d = 1'b1;
    meta_d   = kp.row_in;
    sync_d   = meta_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    rel_d    = rel_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    held_d   = held_q;

    if (dwell_end) begin
      unique case (state_q)
        ST_SCAN: begin
          if (!row_hit) begin
            col_d = col_q + COL_BITS'(1);
          end else begin
            cand_d   = cand;
            stable_d = DW'(1);
            if (DEBOUNCE == 1) begin
              code_d  = cand;
              valid_d = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
              state_d = ST_HELD;
            end else begin
              state_d = ST_DEB;
            end
          end
        end
        ST_DEB: begin
          if (row_hit && (cand == cand_q)) begin
            stable_d = stable_q + DW'(1);
            if (stable_q + DW'(1) == DW'(DEBOUNCE)) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              rel_d   = '0;
              state_d = ST_HELD;
            end
          end else begin
            // A disagreeing sample restarts from scratch on the same column.
            stable_d = '0;
            state_d  = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (latched_low) begin
            if (rel_q + DW'(1) == DW'(DEBOUNCE)) begin
              held_d  = 1'b0;
              rel_d   = '0;
              col_d   = col_q + COL_BITS'(1);
              state_d = ST_SCAN;
            end else begin
              rel_d = rel_q + DW'(1);
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SCAN;
      dwell_q  <= '0;
      col_q    <= '0;
      col_en_q <= 1'b0;
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      rel_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      col_q    <= col_d;
      col_en_q <= col_en_d;
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      rel_q    <= rel_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  assign kp.col_sel   = col_q;
  assign kp.col_en    = col_en_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign dbg_state    = state_q;
endmodule
